char_ram_arbiter: RTL and testbench

//  Shares the character display RAM's single enable-prioritised port pair between the VGA glyph fetch and
//  the CPU memory-mapped text window. VGA fetches always win. CPU reads/writes are latched, issued on the

---
 rtl/char_ram_arbiter_if.sv | 25 ++
 rtl/char_ram_arbiter.sv | 132 +++++++++++++
 tb/tb_char_ram_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/char_ram_arbiter_if.sv
// CPU-side request/acknowledge bus of the character RAM arbiter.
// The CPU side drives the request; the arbiter returns the ack pulse and the read data.
interface char_ram_arbiter_if #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned H_BITS = 8,
  parameter int unsigned V_BITS = 7
);
  logic              cpuReq;
  logic              cpuWe;
  logic [H_BITS-1:0] cpuH;
  logic [V_BITS-1:0] cpuV;
  logic [DATA_W-1:0] cpuWData;
  logic              cpuAck;
  logic [DATA_W-1:0] cpuRData;

  modport master (
    output cpuReq, cpuWe, cpuH, cpuV, cpuWData,
    input  cpuAck, cpuRData
  );

  modport slave (
    input  cpuReq, cpuWe, cpuH, cpuV, cpuWData,
    output cpuAck, cpuRData
  );
endinterface

// File: rtl/char_ram_arbiter.sv
// Shares the character RAM CPU port between VGA glyph fetch (always wins), latched CPU
// accesses and a clear-screen sequencer that fills the visible area in VGA-free cycles.
module char_ram_arbiter #(
  parameter int unsigned DATA_W    = 6,
  parameter int unsigned H_BITS    = 8,
  parameter int unsigned V_BITS    = 7,
  parameter int unsigned H_COLS    = 80,
  parameter int unsigned V_ROWS    = 60,
  parameter int unsigned STALL_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vgaReq,
  char_ram_arbiter_if.slave cpu,
  input  logic              clrStart,
  input  logic [DATA_W-1:0] clrFill,
  output logic              clrBusy,
  output logic              stallErr,
  output logic              ramVgaEn,
  output logic              ramCpuEn,
  output logic              ramCpuWe,
  output logic [H_BITS-1:0] ramH,
  output logic [V_BITS-1:0] ramV,
  output logic [DATA_W-1:0] ramWData,
  input  logic [DATA_W-1:0] ramCpuData
);

  localparam int unsigned STALL_W = $clog2(STALL_MAX + 2);

  typedef enum logic [1:0] {IDLE, PEND, DONE, CLEAR} state_t;

  state_t             state;
  logic               weQ;
  logic [H_BITS-1:0]  hQ;
  logic [V_BITS-1:0]  vQ;
  logic [DATA_W-1:0]  dataQ;
  logic [DATA_W-1:0]  fillQ;
  logic [H_BITS-1:0]  col;
  logic [V_BITS-1:0]  row;
  logic               clrPending;
  logic [STALL_W-1:0] stallCnt;
  logic               lastCol;
  logic               lastCell;

  assign lastCol  = (col == H_BITS'(H_COLS - 1));
  assign lastCell = lastCol && (row == V_BITS'(V_ROWS - 1));

  // Arbitration state machine; a clear request that cannot start yet is parked in clrPending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      weQ        <= 1'b0;
      hQ         <= '0;
      vQ         <= '0;
      dataQ      <= '0;
      fillQ      <= '0;
      col        <= '0;
      row        <= '0;
      clrPending <= 1'b0;
      stallCnt   <= '0;
      stallErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu.cpuReq) begin
            weQ   <= cpu.cpuWe;
            hQ    <= cpu.cpuH;
            vQ    <= cpu.cpuV;
            dataQ <= cpu.cpuWData;
            state <= PEND;
            if (clrStart) begin
              clrPending <= 1'b1;
              fillQ      <= clrFill;
            end
          end else if (clrStart || clrPending) begin
            if (clrStart) fillQ <= clrFill;
            clrPending <= 1'b0;
            col        <= '0;
            row        <= '0;
            state      <= CLEAR;
          end
        end
        PEND: begin
          if (clrStart) begin
            clrPending <= 1'b1;
            fillQ      <= clrFill;
          end
          if (vgaReq) begin
            if (stallCnt != '1) stallCnt <= stallCnt + 1'b1;
            // The count after this stall cycle exceeds the limit.
            if (stallCnt >= STALL_W'(STALL_MAX)) stallErr <= 1'b1;
          end else begin
            stallCnt <= '0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (clrStart) begin
            clrPending <= 1'b1;
            fillQ      <= clrFill;
          end
          state <= IDLE;
        end
        CLEAR: begin
          if (!vgaReq) begin
            if (lastCell) begin
              state <= IDLE;
            end else if (lastCol) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM-side drive: VGA masks every CPU-side enable in the same cycle.
  assign ramVgaEn     = vgaReq;
  assign ramCpuEn     = !vgaReq && ((state == PEND) || (state == CLEAR));
  assign ramCpuWe     = !vgaReq && (((state == PEND) && weQ) || (state == CLEAR));
  assign ramH         = (state == CLEAR) ? col   : hQ;
  assign ramV         = (state == CLEAR) ? row   : vQ;
  assign ramWData     = (state == CLEAR) ? fillQ : dataQ;
  assign clrBusy      = clrPending || (state == CLEAR);
  assign cpu.cpuAck   = (state == DONE);
  assign cpu.cpuRData = ramCpuData;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Directed and randomized bench for char_ram_arbiter with a behavioural RAM and an
// expected-contents model of the character display.
module tb_char_ram_arbiter;

  localparam int unsigned DATA_W    = 6;
  localparam int unsigned H_BITS    = 8;
  localparam int unsigned V_BITS    = 7;
  localparam int unsigned H_COLS    = 80;
  localparam int unsigned V_ROWS    = 60;
  localparam int unsigned STALL_MAX = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              vgaReq;
  logic              clrStart;
  logic [DATA_W-1:0] clrFill;
  logic              clrBusy;
  logic              stallErr;
  logic              ramVgaEn;
  logic              ramCpuEn;
  logic              ramCpuWe;
  logic [H_BITS-1:0] ramH;
  logic [V_BITS-1:0] ramV;
  logic [DATA_W-1:0] ramWData;
  logic [DATA_W-1:0] ramCpuData;

  char_ram_arbiter_if #(.DATA_W(DATA_W), .H_BITS(H_BITS), .V_BITS(V_BITS)) cpuIf ();

  char_ram_arbiter #(
    .DATA_W(DATA_W), .H_BITS(H_BITS), .V_BITS(V_BITS),
    .H_COLS(H_COLS), .V_ROWS(V_ROWS), .STALL_MAX(STALL_MAX)
  ) dut (
    .clk(clk), .reset(reset), .vgaReq(vgaReq), .cpu(cpuIf),
    .clrStart(clrStart), .clrFill(clrFill), .clrBusy(clrBusy), .stallErr(stallErr),
    .ramVgaEn(ramVgaEn), .ramCpuEn(ramCpuEn), .ramCpuWe(ramCpuWe),
    .ramH(ramH), .ramV(ramV), .ramWData(ramWData), .ramCpuData(ramCpuData)
  );

  always #5 clk = ~clk;

  // Behavioural character RAM (1-cycle read latency) plus write/overlap monitors.
  logic [DATA_W-1:0] mem    [0:32767];
  logic [DATA_W-1:0] expMem [0:32767];
  int unsigned wrTotal  = 0;
  int unsigned oobTotal = 0;
  int unsigned overlap  = 0;

  always @(posedge clk) begin
    if (ramCpuEn) begin
      if (ramCpuWe) begin
        mem[{ramV, ramH}] <= ramWData;
        wrTotal++;
        if (ramH >= H_BITS'(H_COLS) || ramV >= V_BITS'(V_ROWS)) oobTotal++;
      end else begin
        ramCpuData <= mem[{ramV, ramH}];
      end
      if (vgaReq) overlap++;
    end
  end

  int   nAssert = 0;
  int   nFail   = 0;
  logic errModel;

  function automatic int idx(input int r, input int c);
    return r * 256 + c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One CPU access with a chosen number of VGA stall cycles; checks every cycle until ack.
  task automatic cpuAccess(input string tag, input logic we, input logic [V_BITS-1:0] v,
                           input logic [H_BITS-1:0] h, input logic [DATA_W-1:0] wd,
                           input int stalls, input logic expBusy);
    int badCyc;
    badCyc         = 0;
    cpuIf.cpuReq   = 1'b1;
    cpuIf.cpuWe    = we;
    cpuIf.cpuV     = v;
    cpuIf.cpuH     = h;
    cpuIf.cpuWData = wd;
    vgaReq         = 1'b0;
    tick();
    clrStart = 1'b0;
    if (stalls > int'(STALL_MAX)) errModel = 1'b1;
    for (int i = 0; i <= stalls; i++) begin
      vgaReq = (i < stalls);
      #1;
      if (ramCpuEn !== (i == stalls) || cpuIf.cpuAck !== 1'b0 || clrBusy !== expBusy) badCyc++;
      if (i == stalls)
        chk({tag, " grant"}, {ramCpuWe, ramV, ramH, ramWData}, {we, v, h, wd});
      tick();
    end
    vgaReq = 1'($urandom_range(0, 1));
    #1;
    chk({tag, " ack"}, cpuIf.cpuAck, 1);
    chk({tag, " stallErr"}, stallErr, errModel);
    if (!we) chk({tag, " rdata"}, cpuIf.cpuRData, expMem[{v, h}]);
    else expMem[{v, h}] = wd;
    if (clrBusy !== expBusy) badCyc++;
    cpuIf.cpuReq = 1'b0;
    vgaReq       = 1'b0;
    tick();
    #1;
    if (cpuIf.cpuAck !== 1'b0 || ramCpuEn !== 1'b0 || clrBusy !== expBusy) badCyc++;
    chk({tag, " cycles"}, badCyc, 0);
  endtask

  // Runs a clear to completion with 1-in-8 VGA stalls and a stray clrStart mid-way.
  task automatic runClear(input string tag, input int extra, input logic [DATA_W-1:0] fill);
    int busy, st, mism;
    int unsigned w0, o0;
    busy = 0; st = 0; mism = 0;
    w0 = wrTotal; o0 = oobTotal;
    for (int i = 0; i < 20000; i++) begin
      vgaReq   = (i >= extra) ? ($urandom_range(0, 7) == 0) : 1'b0;
      clrStart = (i == 100);
      clrFill  = (i == 100) ? ~fill : fill;
      #1;
      if (!clrBusy) break;
      busy++;
      if (vgaReq) st++;
      tick();
    end
    clrStart = 1'b0;
    vgaReq   = 1'b0;
    chk({tag, " busy width"}, busy, 32'(int'(H_COLS * V_ROWS) + st + extra));
    chk({tag, " writes"}, wrTotal - w0, H_COLS * V_ROWS);
    chk({tag, " oob writes"}, oobTotal - o0, 0);
    for (int r = 0; r < int'(V_ROWS); r++)
      for (int c = 0; c < int'(H_COLS); c++) begin
        expMem[idx(r, c)] = fill;
        if (mem[idx(r, c)] !== fill) mism++;
      end
    chk({tag, " contents"}, mism, 0);
  endtask

  logic [14:0]       a;
  logic [DATA_W-1:0] d;
  logic [14:0]       q[$];
  int                s;
  int unsigned       w0, w1;
  int                mism;

  initial begin
    reset = 1'b0; vgaReq = 1'b0; clrStart = 1'b0; clrFill = '0;
    cpuIf.cpuReq = 1'b0; cpuIf.cpuWe = 1'b0; cpuIf.cpuH = '0; cpuIf.cpuV = '0; cpuIf.cpuWData = '0;
    errModel = 1'b0;
    tick(); tick();
    #1;
    chk("reset ctrl", {cpuIf.cpuAck, clrBusy, stallErr, ramCpuEn, ramCpuWe}, 0);
    chk("reset addr", {ramV, ramH, ramWData}, 0);
    reset = 1'b1;
    tick();

    // T1 write then read back, no contention
    cpuAccess("T1 wr", 1'b1, 7'd3, 8'd5, 6'h2A, 0, 1'b0);
    cpuAccess("T1 rd", 1'b0, 7'd3, 8'd5, 6'h00, 0, 1'b0);
    // T2 three VGA stall cycles
    cpuAccess("T2 rd", 1'b0, 7'd3, 8'd5, 6'h00, 3, 1'b0);
    // Exactly STALL_MAX stalls does not flag an error
    cpuAccess("stall16", 1'b1, 7'd7, 8'd9, 6'h11, 16, 1'b0);

    // Random accesses against the expected-contents model
    repeat (24) begin
      s = $urandom_range(0, 4);
      if (q.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = 15'($urandom);
        d = 6'($urandom);
        cpuAccess("rnd wr", 1'b1, a[14:8], a[7:0], d, s, 1'b0);
        q.push_back(a);
      end else begin
        a = q[$urandom_range(0, q.size() - 1)];
        cpuAccess("rnd rd", 1'b0, a[14:8], a[7:0], 6'h00, s, 1'b0);
      end
    end

    cpuAccess("oob wr0", 1'b1, 7'd0, 8'd80, 6'h33, 0, 1'b0);
    cpuAccess("oob wr1", 1'b1, 7'd10, 8'd90, 6'h2C, 1, 1'b0);

    // T5 long stall sets the sticky error; only reset clears it
    cpuAccess("T5 rd", 1'b0, 7'd7, 8'd9, 6'h00, 20, 1'b0);
    #1;
    chk("T5 sticky", stallErr, 1);
    reset = 1'b0;
    #1;
    chk("T5 reset clears", stallErr, 0);
    errModel = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // T3 clear to 0x00
    clrFill  = 6'h00;
    clrStart = 1'b1;
    tick();
    clrStart = 1'b0;
    runClear("T3", 0, 6'h00);
    chk("T3 cell 0,80", mem[idx(0, 80)], 6'h33);
    chk("T3 cell 10,90", mem[idx(10, 90)], 6'h2C);

    // T4 CPU request and clear request collide: CPU first, clear follows
    clrStart = 1'b1;
    clrFill  = 6'h3F;
    cpuAccess("T4 wr", 1'b1, 7'd10, 8'd90, 6'h0E, 2, 1'b1);
    runClear("T4", 1, 6'h3F);
    chk("T4 cell 10,90", mem[idx(10, 90)], 6'h0E);
    chk("T4 cell 0,80", mem[idx(0, 80)], 6'h33);

    // T6 reset after 1000 cells of a clear
    clrFill  = 6'h15;
    clrStart = 1'b1;
    tick();
    clrStart = 1'b0;
    vgaReq   = 1'b0;
    w0 = wrTotal;
    for (int i = 0; i < 2000; i++) begin
      if (wrTotal - w0 >= 1000) break;
      tick();
    end
    chk("T6 writes before reset", wrTotal - w0, 1000);
    reset = 1'b0;
    #1;
    chk("T6 reset ctrl", {cpuIf.cpuAck, clrBusy, stallErr, ramCpuEn, ramCpuWe}, 0);
    chk("T6 reset addr", {ramV, ramH, ramWData}, 0);
    w1 = wrTotal;
    tick(); tick(); tick();
    reset = 1'b1;
    repeat (20) tick();
    #1;
    chk("T6 no writes after reset", wrTotal - w1, 0);
    chk("T6 busy low", clrBusy, 0);
    mism = 0;
    for (int r = 0; r < int'(V_ROWS); r++)
      for (int c = 0; c < int'(H_COLS); c++)
        if (mem[idx(r, c)] !== ((r * int'(H_COLS) + c < 1000) ? 6'h15 : expMem[idx(r, c)])) mism++;
    chk("T6 contents", mism, 0);

    chk("vga overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
